// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
// Scan order is chosen by MUX_SCAN_MSB_FIRST_EN (undefined: channel 0 up to 7).
package mux_scan_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef MUX_SCAN_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] FIRST_CH = 3'd7;
    localparam logic [SEL_W-1:0] LAST_CH  = 3'd0;
`else
    localparam logic [SEL_W-1:0] FIRST_CH = 3'd0;
    localparam logic [SEL_W-1:0] LAST_CH  = 3'd7;
`endif

    // Channel that follows ch in the configured scan order.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
`ifdef MUX_SCAN_MSB_FIRST_EN
        return ch - 3'd1;
`else
        return ch + 3'd1;
`endif
    endfunction

endpackage

// File: rtl/mux_8x1.sv
// Existing 8:1 single-bit mux datapath.
module mux_8x1 (
    input  logic [7:0] in,
    input  logic [2:0] sel,
    output logic       out
);

    assign out = in[sel];

endmodule

// File: rtl/mux_scan_serializer.sv
// Serializes a captured 8-bit word through mux_8x1, one channel per dwell period.
// Scan order follows MUX_SCAN_MSB_FIRST_EN (see mux_scan_pkg).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; captures data_in on the accepting edge
// SCAN  | stepping sel through all channels, DWELL cycles each
// DONE  | one-cycle completion pulse, sel holds the last channel
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       data_in,
    output logic [SEL_W-1:0] sel,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

    state_t           state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [7:0]       dwell_cnt, dwell_cnt_n;
    logic [7:0]       captured_word, captured_word_n;

    // State, select, dwell timer and captured word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sel           <= '0;
            dwell_cnt     <= '0;
            captured_word <= '0;
        end else begin
            state         <= state_n;
            sel           <= sel_n;
            dwell_cnt     <= dwell_cnt_n;
            captured_word <= captured_word_n;
        end
    end

    // Next-state logic and decoded status outputs.
    always_comb begin
        state_n         = state;
        sel_n           = sel;
        dwell_cnt_n     = dwell_cnt;
        captured_word_n = captured_word;
        busy            = 1'b0;
        done            = 1'b0;
        bit_valid       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    captured_word_n = data_in;
                    sel_n           = FIRST_CH;
                    dwell_cnt_n     = '0;
                    state_n         = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (dwell_cnt == LAST_CNT) begin
                    bit_valid   = 1'b1;
                    dwell_cnt_n = '0;
                    // sel never wraps: the last channel ends the scan.
                    if (sel == LAST_CH) begin
                        state_n = DONE;
                    end else begin
                        sel_n = next_ch(sel);
                    end
                end else begin
                    dwell_cnt_n = dwell_cnt + 8'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    mux_8x1 u_mux (
        .in  (captured_word),
        .sel (sel),
        .out (bit_out)
    );

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Self-checking bench for mux_scan_serializer: DWELL=1 and DWELL=3 instances,
// directed and random scans checked against a per-cycle scan model.
module tb_mux_scan_serializer;
    import mux_scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_v;
    logic [7:0] data_v;
    int         which;

    logic       st1, st3;
    logic [2:0] sel1, sel3;
    logic       bo1, bv1, busy1, done1;
    logic       bo3, bv3, busy3, done3;

    assign st1 = start_v && (which == 0);
    assign st3 = start_v && (which == 1);

    mux_scan_serializer #(.DWELL(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(st1), .data_in(data_v),
        .sel(sel1), .bit_out(bo1), .bit_valid(bv1), .busy(busy1), .done(done1)
    );

    mux_scan_serializer #(.DWELL(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(st3), .data_in(data_v),
        .sel(sel3), .bit_out(bo3), .bit_valid(bv3), .busy(busy3), .done(done3)
    );

    logic [2:0] o_sel;
    logic       o_bo, o_bv, o_busy, o_done;

    always_comb begin
        if (which == 0) begin
            o_sel = sel1; o_bo = bo1; o_bv = bv1; o_busy = busy1; o_done = done1;
        end else begin
            o_sel = sel3; o_bo = bo3; o_bv = bv3; o_busy = busy3; o_done = done3;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Channel visited at scan position c (0..7) in the configured order.
    function automatic logic [2:0] ch_of(input int c);
`ifdef MUX_SCAN_MSB_FIRST_EN
        return 3'(7 - c);
`else
        return 3'(c);
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"},   32'(o_sel),  32'd0);
        check({tag, "_bout"},  32'(o_bo),   32'd0);
        check({tag, "_bvld"},  32'(o_bv),   32'd0);
        check({tag, "_busy"},  32'(o_busy), 32'd0);
        check({tag, "_done"},  32'(o_done), 32'd0);
    endtask

    // Runs one scan on the selected instance from an idle negedge.
    // inj_at: scan cycle after which start/FF is pulsed (ignored by DUT); -1 none.
    // rst_at: scan cycle after which rst is pulsed; -1 none.
    task automatic run_scan(input int d, input logic [7:0] w, input int inj_at,
                            input int rst_at, output int ones, output int sel_at_one);
        logic [2:0] es;
        ones       = 0;
        sel_at_one = -1;
        data_v  = w;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        data_v  = 8'($urandom);
        for (int k = 0; k < 8 * d; k++) begin
            es = ch_of(k / d);
            check("scan_sel",  32'(o_sel),  32'(es));
            check("scan_bout", 32'(o_bo),   32'(w[es]));
            check("scan_bvld", 32'(o_bv),   32'((k % d) == d - 1));
            check("scan_busy", 32'(o_busy), 32'd1);
            check("scan_done", 32'(o_done), 32'd0);
            if (o_bv && o_bo) begin
                ones++;
                sel_at_one = int'(o_sel);
            end
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_vals("abort");
                for (int j = 0; j < 3 * d + 2; j++) begin
                    @(negedge clk);
                    check("abort_nodone", 32'(o_done), 32'd0);
                    check("abort_idle",   32'(o_busy), 32'd0);
                end
                return;
            end
            if (k == inj_at) begin
                start_v = 1'b1;
                data_v  = 8'hFF;
            end
            @(negedge clk);
            start_v = 1'b0;
        end
        check("done_pulse", 32'(o_done), 32'd1);
        check("done_busy",  32'(o_busy), 32'd0);
        check("done_bvld",  32'(o_bv),   32'd0);
        check("done_sel",   32'(o_sel),  32'(ch_of(7)));
        start_v = 1'b1;
        data_v  = 8'($urandom);
        @(negedge clk);
        start_v = 1'b0;
        check("idle_done", 32'(o_done), 32'd0);
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_sel",  32'(o_sel),  32'(ch_of(7)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones, sal;
        rst     = 1'b1;
        start_v = 1'b0;
        data_v  = 8'h00;
        which   = 0;
        repeat (2) @(negedge clk);
        which = 0; #1; check_reset_vals("rst1");
        which = 1; #1; check_reset_vals("rst3");

        // rst and start together: rst wins
        which   = 0;
        start_v = 1'b1;
        data_v  = 8'hFF;
        @(negedge clk);
        check("rst_vs_start_busy", 32'(o_busy), 32'd0);
        rst     = 1'b0;
        start_v = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 32'(o_busy), 32'd0);

        // DWELL=1 basic
        run_scan(1, 8'hA5, -1, -1, ones, sal);
        check("a5_ones", 32'(ones), 32'd4);

        // one-hot sweep
        for (int i = 0; i < 8; i++) begin
            run_scan(1, 8'(1 << i), -1, -1, ones, sal);
            check("onehot_cnt", 32'(ones), 32'd1);
            check("onehot_sel", 32'(sal),  32'(i));
        end

        // start ignored while busy
        run_scan(1, 8'h0F, 4, -1, ones, sal);
        check("inj_ones", 32'(ones), 32'd4);

        // reset mid-scan, then clean scan
        run_scan(1, 8'h3C, -1, 3, ones, sal);
        run_scan(1, 8'hC3, -1, -1, ones, sal);
        check("after_abort_ones", 32'(ones), 32'd4);

        // random DWELL=1
        for (int r = 0; r < 6; r++) begin
            logic [7:0] w;
            w = 8'($urandom);
            run_scan(1, w, int'($urandom_range(0, 8)) - 1, -1, ones, sal);
            check("rand1_ones", 32'(ones), 32'($countones(w)));
        end

        // DWELL=3
        which = 1;
        @(negedge clk);
        run_scan(3, 8'h81, -1, -1, ones, sal);
        check("d3_81_ones", 32'(ones), 32'd2);
        run_scan(3, 8'h0F, 10, -1, ones, sal);
        check("d3_inj_ones", 32'(ones), 32'd4);
        run_scan(3, 8'h5A, -1, 5, ones, sal);
        for (int r = 0; r < 4; r++) begin
            logic [7:0] w;
            w = 8'($urandom);
            run_scan(3, w, int'($urandom_range(0, 24)) - 1, -1, ones, sal);
            check("rand3_ones", 32'(ones), 32'($countones(w)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
